// File: rtl/imem_ctrl_if.sv
// Fetch-port and memory-bus signal bundle for imem_ctrl.
// The controller uses the master view; the core and memory side use the slave view.
interface imem_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] core_addr;
    logic [31:0]       core_rdata;
    logic              core_rvalid;
    logic              core_stall;
    logic              flush;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_resp_valid;
    logic [31:0]       mem_resp_data;

    modport master (
        input  core_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
        output core_rdata, core_rvalid, core_stall, mem_req_valid, mem_req_addr
    );

    modport slave (
        output core_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
        input  core_rdata, core_rvalid, core_stall, mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/imem_ctrl.sv
// Direct-mapped, word-granular instruction cache with a single-outstanding bus read on miss.
// Optional hit/miss counters are enabled by defining IMEM_CTRL_STATS_EN.
module imem_ctrl #(
    parameter int unsigned IDX_BITS = 6,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic        clk,
    input  logic        rst,
    imem_ctrl_if.master bus
`ifdef IMEM_CTRL_STATS_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses
`endif
);
    localparam int unsigned Entries = 1 << IDX_BITS;
    localparam int unsigned TagW    = ADDR_W - IDX_BITS - 2;

    typedef enum logic [1:0] {StIdle, StLookup, StReq, StWait} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [Entries-1:0]  valid_q;
    logic                flushed_q;
    logic                req_valid_q;
    logic [ADDR_W-1:0]   req_addr_q;
    logic [TagW-1:0]     tag_mem [Entries];
    logic [31:0]         data_mem [Entries];

    logic [IDX_BITS-1:0] idx;
    logic [TagW-1:0]     tag_a;
    logic                hit;
    logic                lookup;
    logic                resp;
    logic                fill_en;
    logic                unused_addr_bits;

    assign idx              = addr_q[IDX_BITS+1:2];
    assign tag_a            = addr_q[ADDR_W-1:IDX_BITS+2];
    assign unused_addr_bits = ^addr_q[1:0];

    assign hit     = valid_q[idx] && (tag_mem[idx] == tag_a);
    assign lookup  = (state_q == StLookup);
    assign resp    = (state_q == StWait) && bus.mem_resp_valid;
    // A flush seen at any point during the miss suppresses the fill.
    assign fill_en = resp && !flushed_q && !bus.flush;

    always_comb begin
        bus.core_rvalid = (lookup && hit) || resp;
        bus.core_rdata  = '0;
        if (lookup && hit) begin
            bus.core_rdata = data_mem[idx];
        end else if (resp) begin
            bus.core_rdata = bus.mem_resp_data;
        end
        bus.core_stall = (lookup && !hit) || (state_q == StReq) ||
                         ((state_q == StWait) && !bus.mem_resp_valid);
    end

    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_req_addr  = req_addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            valid_q     <= '0;
            flushed_q   <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
        end else begin
            if (!bus.core_stall) begin
                addr_q <= bus.core_addr;
            end

            unique case (state_q)
                StIdle: state_q <= StLookup;
                StLookup: begin
                    if (!hit) begin
                        state_q     <= StReq;
                        req_valid_q <= 1'b1;
                        req_addr_q  <= {addr_q[ADDR_W-1:2], 2'b00};
                    end
                end
                StReq: begin
                    if (bus.mem_req_ready) begin
                        state_q     <= StWait;
                        req_valid_q <= 1'b0;
                    end
                end
                StWait: begin
                    if (bus.mem_resp_valid) begin
                        state_q <= StLookup;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (resp) begin
                flushed_q <= 1'b0;
            end else if (bus.flush && ((state_q == StReq) || (state_q == StWait))) begin
                flushed_q <= 1'b1;
            end

            if (bus.flush) begin
                valid_q <= '0;
            end else if (fill_en) begin
                valid_q[idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays need no reset: the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[idx]  <= tag_a;
            data_mem[idx] <= bus.mem_resp_data;
        end
    end

`ifdef IMEM_CTRL_STATS_EN
    logic [31:0] hits_q;
    logic [31:0] misses_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (lookup) begin
            if (hit) begin
                hits_q <= hits_q + 32'd1;
            end else begin
                misses_q <= misses_q + 32'd1;
            end
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`endif
endmodule

// File: tb/tb_imem_ctrl.sv
// Self-checking bench for imem_ctrl: directed scenarios plus a randomized fetch stream
// checked against an array model of the cache contents.
module tb_imem_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   hs_cnt;
    int   exp_hs;
    int   exp_hits;
    int   exp_misses;

    bit          m_valid [64];
    logic [23:0] m_tag   [64];
    logic [31:0] m_data  [64];

    imem_ctrl_if #(.ADDR_W(32)) bus ();

`ifdef IMEM_CTRL_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    imem_ctrl #(.IDX_BITS(6), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef IMEM_CTRL_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst && bus.mem_req_valid && bus.mem_req_ready) hs_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.flush          = 1'b0;
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        model_clear();
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    // Presents addr in the current (accepting) cycle and follows it to delivery.
    // fl_mode: 0 none, 1 flush in WAIT, 2 flush with response, 3 flush during a hit.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                         input int rdy_dly, input int rsp_dly, input int fl_mode);
        logic [5:0]  idx;
        logic [23:0] tg;
        logic [31:0] waddr;
        bit          hit;
        bit          drop;
        int          rd;
        idx   = addr[7:2];
        tg    = addr[31:8];
        waddr = {addr[31:2], 2'b00};
        drop  = 1'b0;
        rd    = (fl_mode == 1 && rsp_dly == 0) ? 1 : rsp_dly;
        bus.core_addr = addr;
        step();
        hit = m_valid[idx] && (m_tag[idx] == tg);
        if (hit) begin
            if (fl_mode == 3) bus.flush = 1'b1;
            #1;
            n_checks++;
            if (bus.core_rvalid !== 1'b1 || bus.core_rdata !== m_data[idx] ||
                bus.core_stall !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL hit %h: rvalid=%b rdata=%h stall=%b req=%b, expected 1 %h 0 0",
                         addr, bus.core_rvalid, bus.core_rdata, bus.core_stall,
                         bus.mem_req_valid, m_data[idx]);
            end
            exp_hits++;
            if (fl_mode == 3) model_clear();
        end else begin
            n_checks++;
            if (bus.core_rvalid !== 1'b0 || bus.core_stall !== 1'b1) begin
                n_errors++;
                $display("FAIL miss_detect %h: rvalid=%b stall=%b, expected 0 1",
                         addr, bus.core_rvalid, bus.core_stall);
            end
            exp_misses++;
            step();
            for (int i = 0; i <= rdy_dly; i++) begin
                if (i == rdy_dly) bus.mem_req_ready = 1'b1;
                #1;
                n_checks++;
                if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== waddr ||
                    bus.core_stall !== 1'b1 || bus.core_rvalid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL req %h cyc %0d: valid=%b addr=%h stall=%b, expected 1 %h 1",
                             addr, i, bus.mem_req_valid, bus.mem_req_addr, bus.core_stall, waddr);
                end
                step();
            end
            exp_hs++;
            for (int i = 0; i < rd; i++) begin
                n_checks++;
                if (bus.core_stall !== 1'b1 || bus.core_rvalid !== 1'b0 ||
                    bus.mem_req_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL wait %h cyc %0d: stall=%b rvalid=%b req=%b, expected 1 0 0",
                             addr, i, bus.core_stall, bus.core_rvalid, bus.mem_req_valid);
                end
                if (fl_mode == 1 && i == 0) begin
                    bus.flush = 1'b1;
                    drop      = 1'b1;
                end
                step();
            end
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = data;
            if (fl_mode == 2) begin
                bus.flush = 1'b1;
                drop      = 1'b1;
            end
            #1;
            n_checks++;
            if (bus.core_rvalid !== 1'b1 || bus.core_rdata !== data || bus.core_stall !== 1'b0) begin
                n_errors++;
                $display("FAIL deliver %h: rvalid=%b rdata=%h stall=%b, expected 1 %h 0",
                         addr, bus.core_rvalid, bus.core_rdata, bus.core_stall, data);
            end
            if (drop) begin
                model_clear();
            end else begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
                m_data[idx]  = data;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.core_rvalid !== 1'b0 || bus.core_stall !== 1'b0 || bus.core_rdata !== 32'h0 ||
            bus.mem_req_valid !== 1'b0 || bus.mem_req_addr !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_state: rvalid=%b stall=%b rdata=%h req=%b raddr=%h, expected zeros",
                     bus.core_rvalid, bus.core_stall, bus.core_rdata,
                     bus.mem_req_valid, bus.mem_req_addr);
        end
`ifdef IMEM_CTRL_STATS_EN
        n_checks++;
        if (stat_hits !== 32'd0 || stat_misses !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_stats: hits=%0d misses=%0d, expected 0 0", stat_hits, stat_misses);
        end
`endif
        step();
        rst = 1'b1;
    endtask

    task automatic test_cold_miss();
        int hs0;
        apply_reset();
        hs0 = hs_cnt;
        fetch(32'h0000_0100, 32'h0000_0013, 0, 2, 0);
        fetch(32'h0000_0100, 32'h0, 0, 0, 0);
        n_checks++;
        if (hs_cnt - hs0 !== 1) begin
            n_errors++;
            $display("FAIL cold_handshakes: got %0d, expected 1", hs_cnt - hs0);
        end
    endtask

    task automatic test_hit_stream();
        int hs0;
        apply_reset();
        for (int i = 0; i < 4; i++) fetch(32'h100 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 0, 0, 0);
        hs0 = hs_cnt;
        for (int i = 0; i < 4; i++) fetch(32'h100 + 32'(i * 4), 32'h0, 0, 0, 0);
        n_checks++;
        if (hs_cnt !== hs0) begin
            n_errors++;
            $display("FAIL stream_no_bus: handshakes %0d, expected %0d", hs_cnt, hs0);
        end
`ifdef IMEM_CTRL_STATS_EN
        n_checks++;
        if (stat_hits !== 32'd4 || stat_misses !== 32'd4) begin
            n_errors++;
            $display("FAIL stream_stats: hits=%0d misses=%0d, expected 4 4", stat_hits, stat_misses);
        end
`endif
    endtask

    task automatic test_backpressure();
        int hs0;
        hs0 = hs_cnt;
        fetch(32'h0000_0200, 32'hBEEF_0200, 5, 1, 0);
        n_checks++;
        if (hs_cnt - hs0 !== 1) begin
            n_errors++;
            $display("FAIL backpressure_handshakes: got %0d, expected 1", hs_cnt - hs0);
        end
    endtask

    task automatic test_aliasing();
        int hs0;
        apply_reset();
        hs0 = hs_cnt;
        fetch(32'h0000_0004, 32'hAAAA_0004, 0, 0, 0);
        fetch(32'h0000_0104, 32'hBBBB_0104, 0, 1, 0);
        fetch(32'h0000_0004, 32'hCCCC_0004, 1, 0, 0);
        fetch(32'h0000_0004, 32'h0, 0, 0, 0);
        n_checks++;
        if (hs_cnt - hs0 !== 3) begin
            n_errors++;
            $display("FAIL alias_handshakes: got %0d, expected 3", hs_cnt - hs0);
        end
    endtask

    task automatic test_flush_wait();
        int hs0;
        fetch(32'h0000_0080, 32'h1111_0080, 0, 0, 0);
        hs0 = hs_cnt;
        fetch(32'h0000_0300, 32'h2222_0300, 0, 2, 1);
        fetch(32'h0000_0300, 32'h3333_0300, 0, 0, 0);
        fetch(32'h0000_0080, 32'h4444_0080, 0, 0, 0);
        n_checks++;
        if (hs_cnt - hs0 !== 3) begin
            n_errors++;
            $display("FAIL flush_handshakes: got %0d, expected 3", hs_cnt - hs0);
        end
    endtask

    task automatic test_reset_mid_miss();
        int hs0;
        bus.core_addr = 32'h0000_0400;
        step();
        step();
        n_checks++;
        if (bus.mem_req_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL midmiss_req: valid=%b, expected 1", bus.mem_req_valid);
        end
        hs0 = hs_cnt;
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.mem_req_valid !== 1'b0 || bus.core_stall !== 1'b0 || bus.core_rvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL midmiss_async: req=%b stall=%b rvalid=%b, expected 0 0 0",
                     bus.mem_req_valid, bus.core_stall, bus.core_rvalid);
        end
        step();
        rst = 1'b1;
        model_clear();
        exp_hits   = 0;
        exp_misses = 0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'hDEAD_DEAD;
        #1;
        n_checks++;
        if (bus.core_rvalid !== 1'b0 || bus.mem_req_valid !== 1'b0 || bus.core_stall !== 1'b0) begin
            n_errors++;
            $display("FAIL stray_resp: rvalid=%b req=%b stall=%b, expected 0 0 0",
                     bus.core_rvalid, bus.mem_req_valid, bus.core_stall);
        end
        fetch(32'h0000_0400, 32'h5555_0400, 0, 0, 0);
        n_checks++;
        if (hs_cnt - hs0 !== 1) begin
            n_errors++;
            $display("FAIL midmiss_fresh_req: handshakes %0d, expected 1", hs_cnt - hs0);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          m;
        int          fm;
        for (int n = 0; n < 120; n++) begin
            a = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 7)) << 2) |
                32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a | 32'h8000_0000;
            m  = $urandom_range(0, 19);
            fm = (m < 16) ? 0 : (m - 15 > 3 ? 3 : m - 15);
            fetch(a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), fm);
        end
        n_checks++;
        if (hs_cnt !== exp_hs) begin
            n_errors++;
            $display("FAIL random_handshakes: got %0d, expected %0d", hs_cnt, exp_hs);
        end
`ifdef IMEM_CTRL_STATS_EN
        n_checks++;
        if (stat_hits !== 32'(exp_hits) || stat_misses !== 32'(exp_misses)) begin
            n_errors++;
            $display("FAIL random_stats: hits=%0d misses=%0d, expected %0d %0d",
                     stat_hits, stat_misses, exp_hits, exp_misses);
        end
`endif
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        hs_cnt     = 0;
        exp_hs     = 0;
        exp_hits   = 0;
        exp_misses = 0;
        rst                = 1'b0;
        bus.core_addr      = '0;
        bus.flush          = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        model_clear();
        test_reset();
        test_cold_miss();
        test_hit_stream();
        test_backpressure();
        test_aliasing();
        test_flush_wait();
        test_reset_mid_miss();
        apply_reset();
        exp_hs = hs_cnt;
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
